// File: rtl/axis_checker.sv
// AXI-Stream sink that checks a fixed-length incrementing sequence (SEED + index),
// captures every accepted word for readback and reports pass/fail and error statistics.
module axis_checker #(
    parameter int unsigned D_W          = 8,
    parameter int unsigned SEED         = 0,
    parameter int unsigned LENGTH       = 32,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_axis_valid,
    input  logic [D_W-1:0] s_axis_data,
    output logic           s_axis_ready,
    output logic           done,
    output logic           pass,
    output logic [31:0]    err_count,
    output logic [31:0]    first_err_idx,
    input  logic [31:0]    rd_addr,
    output logic [D_W-1:0] rd_data
);

    localparam int unsigned AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

    state_e         state_q;
    logic [31:0]    w_ptr_q;
    logic [31:0]    stall_cnt_q;
    logic [D_W-1:0] mem [LENGTH];

    logic           stall;
    logic           accept;
    logic           mismatch;
    logic           last_word;
    logic [D_W-1:0] expected;
    logic [31:0]    err_count_d;

    // Ready comes only from registered state so it never loops back through valid.
    always_comb begin
        stall        = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_PERIOD - 1);
        s_axis_ready = (state_q == StRecv) && !stall;
        accept       = s_axis_valid && s_axis_ready;
        expected     = D_W'(SEED + w_ptr_q);
        mismatch     = accept && (s_axis_data != expected);
        last_word    = (w_ptr_q == LENGTH - 1);
        err_count_d  = err_count + {31'b0, mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            w_ptr_q       <= '0;
            stall_cnt_q   <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else begin
            case (state_q)
                StIdle: state_q <= StRecv;
                StRecv: begin
                    if (STALL_PERIOD != 0) begin
                        stall_cnt_q <= stall ? '0 : stall_cnt_q + 32'd1;
                    end
                    if (accept) begin
                        w_ptr_q   <= w_ptr_q + 32'd1;
                        err_count <= err_count_d;
                        if (mismatch && (first_err_idx == '1)) begin
                            first_err_idx <= w_ptr_q;
                        end
                        // Final word's own mismatch is folded in via err_count_d.
                        if (last_word) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            pass    <= (err_count_d == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture buffer is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[w_ptr_q[AW-1:0]] <= s_axis_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= (rd_addr < LENGTH) ? mem[rd_addr[AW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_axis_checker.sv
// Randomised scoreboard bench for axis_checker: three instances cover default, backpressure
// and wrapping-seed configurations against a sequence-level reference model.
module tb_axis_checker;

    localparam int LEN = 32;

    typedef logic [7:0] q8_t [$];
    typedef struct {
        int          k;
        logic [31:0] ec;
        logic [31:0] fe;
        logic        ps;
    } res_t;
    typedef struct {
        int         k;
        int         c;
        logic [7:0] v;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        vld [3];
    logic [7:0]  dat [3];
    logic [31:0] rda [3];
    logic        rdy [3];
    logic        dn  [3];
    logic        ps  [3];
    logic [31:0] ec  [3];
    logic [31:0] fe  [3];
    logic [7:0]  rdd [3];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc_g = 0;
    res_t res_q[$];
    rd_t  rd_q[$];
    logic dn_prev [3];
    res_t mon_r;
    rd_t  mon_rr;

    axis_checker u_def (
        .clk(clk), .rst(rst[0]), .s_axis_valid(vld[0]), .s_axis_data(dat[0]),
        .s_axis_ready(rdy[0]), .done(dn[0]), .pass(ps[0]), .err_count(ec[0]),
        .first_err_idx(fe[0]), .rd_addr(rda[0]), .rd_data(rdd[0])
    );

    axis_checker #(.STALL_PERIOD(4)) u_stall (
        .clk(clk), .rst(rst[1]), .s_axis_valid(vld[1]), .s_axis_data(dat[1]),
        .s_axis_ready(rdy[1]), .done(dn[1]), .pass(ps[1]), .err_count(ec[1]),
        .first_err_idx(fe[1]), .rd_addr(rda[1]), .rd_data(rdd[1])
    );

    axis_checker #(.SEED(250)) u_wrap (
        .clk(clk), .rst(rst[2]), .s_axis_valid(vld[2]), .s_axis_data(dat[2]),
        .s_axis_ready(rdy[2]), .done(dn[2]), .pass(ps[2]), .err_count(ec[2]),
        .first_err_idx(fe[2]), .rd_addr(rda[2]), .rd_data(rdd[2])
    );

    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: word i must equal (seed + i) mod 256.
    function automatic q8_t make_words(input int seed);
        q8_t w;
        for (int i = 0; i < LEN; i++) w.push_back(8'((seed + i) % 256));
        return w;
    endfunction

    function automatic void model(input q8_t w, input int seed, output logic [31:0] e,
                                  output logic [31:0] f, output logic p);
        e = 0;
        f = 32'hFFFF_FFFF;
        for (int i = 0; i < w.size(); i++) begin
            if (w[i] != 8'((seed + i) % 256)) begin
                if (f == 32'hFFFF_FFFF) f = i;
                e++;
            end
        end
        p = (e == 0);
    endfunction

    // Monitor: scores final status on the rising edge of done and readback one cycle later.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dn[k] === 1'b1 && dn_prev[k] !== 1'b1) begin
                if (res_q.size() == 0) begin
                    check("sb_result_expected", 0, 1);
                end else begin
                    mon_r = res_q.pop_front();
                    check("sb_dut_index", k, mon_r.k);
                    check("err_count", ec[k], mon_r.ec);
                    check("first_err_idx", fe[k], mon_r.fe);
                    check("pass", {31'b0, ps[k]}, {31'b0, mon_r.ps});
                end
            end
            dn_prev[k] <= dn[k];
        end
        if (rd_q.size() > 0 && rd_q[0].c < cyc_g) begin
            mon_rr = rd_q.pop_front();
            check("rd_data", {24'b0, rdd[mon_rr.k]}, {24'b0, mon_rr.v});
        end
    end

    task automatic rst_dut(input int k);
        rst[k] = 1'b1;
        vld[k] = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", {31'b0, rdy[k]}, 0);
        check("rst_done", {31'b0, dn[k]}, 0);
        check("rst_pass", {31'b0, ps[k]}, 0);
        check("rst_err_count", ec[k], 0);
        check("rst_first_err", fe[k], 32'hFFFF_FFFF);
        check("rst_rd_data", {24'b0, rdd[k]}, 0);
        rst[k] = 1'b0;
    endtask

    task automatic rd(input int k, input int addr, input logic [7:0] v);
        rda[k] = addr;
        rd_q.push_back('{k: k, c: cyc_g, v: v});
        @(posedge clk); #1;
    endtask

    task automatic read_all(input int k, input q8_t w);
        for (int i = 0; i < LEN; i++) rd(k, i, w[i]);
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid.
    task automatic run(input int k, input int seed, input int period, input int mode,
                       input int abort_at, input q8_t w);
        int          idx = 0;
        int          rc = -1;
        int          cyc = 0;
        int          last_rc = 0;
        bit          acc;
        logic [31:0] e;
        logic [31:0] f;
        logic        p;
        if (abort_at < 0) begin
            model(w, seed, e, f, p);
            res_q.push_back('{k: k, ec: e, fe: f, ps: p});
        end
        check("done_low_at_start", {31'b0, dn[k]}, 0);
        while (idx < LEN && cyc < 200) begin
            case (mode)
                0:       vld[k] = 1'b1;
                1:       vld[k] = (cyc % 2 == 0);
                default: vld[k] = 1'($urandom_range(0, 1));
            endcase
            dat[k] = vld[k] ? w[idx] : 8'($urandom);
            if (rdy[k] && rc < 0) rc = 0;
            if (rc >= 0) begin
                check("ready_pattern", {31'b0, rdy[k]},
                      (period == 0) ? 1 : {31'b0, (rc % period) != period - 1});
            end
            acc = vld[k] && rdy[k];
            @(posedge clk); #1;
            cyc++;
            if (rc >= 0) rc++;
            if (acc) begin
                idx++;
                last_rc = rc;
                if (idx == abort_at) break;
            end
        end
        vld[k] = 1'b0;
        if (abort_at >= 0 && idx == abort_at) return;
        if (idx < LEN) begin
            check("accept_timeout", idx, LEN);
            return;
        end
        check("done_after_last", {31'b0, dn[k]}, 1);
        check("ready_in_done", {31'b0, rdy[k]}, 0);
        if (mode == 0 && period == 0) check("consecutive_accepts", last_rc, LEN);
        if (mode == 0 && period == 4) check("stall_budget", {31'b0, last_rc <= 42}, 1);
    endtask

    q8_t w;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            vld[k] = 1'b0;
            dat[k] = '0;
            rda[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Clean run, valid held high.
        rst_dut(0);
        w = make_words(0);
        run(0, 0, 0, 0, -1, w);
        read_all(0, w);

        // Two injected errors, then readback including out-of-range address.
        rst_dut(0);
        w = make_words(0);
        w[5] = 8'hAA;
        w[20] = 8'h00;
        run(0, 0, 0, 0, -1, w);
        rd(0, 5, 8'hAA);
        rd(0, 40, 8'h00);
        read_all(0, w);

        // Valid toggling every other cycle.
        rst_dut(0);
        w = make_words(0);
        run(0, 0, 0, 1, -1, w);
        read_all(0, w);

        // Reset after 10 accepts (one already in error), then a full clean run.
        rst_dut(0);
        w = make_words(0);
        w[2] = 8'h55;
        run(0, 0, 0, 0, 10, w);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        check("midrst_done", {31'b0, dn[0]}, 0);
        check("midrst_err_count", ec[0], 0);
        check("midrst_first_err", fe[0], 32'hFFFF_FFFF);
        check("midrst_ready", {31'b0, rdy[0]}, 0);
        w = make_words(0);
        run(0, 0, 0, 0, -1, w);
        read_all(0, w);

        // Random corruption with random valid.
        rst_dut(0);
        w = make_words(0);
        for (int i = 0; i < LEN; i++) if ($urandom_range(0, 5) == 0) w[i] = 8'($urandom);
        run(0, 0, 0, 2, -1, w);
        read_all(0, w);

        // Periodic backpressure.
        rst_dut(1);
        w = make_words(0);
        run(1, 0, 4, 0, -1, w);
        read_all(1, w);

        // Seed wrapping past 255, then random corruption on the same instance.
        rst_dut(2);
        w = make_words(250);
        run(2, 250, 0, 0, -1, w);
        read_all(2, w);
        rst_dut(2);
        w = make_words(250);
        for (int i = 0; i < LEN; i++) if ($urandom_range(0, 3) == 0) w[i] = 8'($urandom);
        run(2, 250, 0, 2, -1, w);
        read_all(2, w);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", res_q.size() + rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
